// File: rtl/cpu.sv
`default_nettype none
// ============================================================================
//  Module   : cpu
//  Brief    : Single-cycle, non-pipelined RV32I core with combinational
//             instruction ROM and byte-lane data memory ports.
//  Revision : 1.0  initial release
// ============================================================================
module cpu #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rstl,
    output logic [XLEN-1:0]   rom_addr,
    input  logic [XLEN-1:0]   rom_data,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN/8-1:0] mem_r,
    output logic [XLEN/8-1:0] mem_w,
    output logic [XLEN-1:0]   mem_din,
    input  logic [XLEN-1:0]   mem_dout
);

    localparam int BE_W = XLEN / 8;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6f;

    localparam logic [BE_W-1:0] BE_BYTE = BE_W'(1);
    localparam logic [BE_W-1:0] BE_HALF = BE_W'(3);
    localparam logic [BE_W-1:0] BE_WORD = BE_W'(15);

    logic [XLEN-1:0] pc, pc_next, pc_plus4;
    logic [XLEN-1:0] regs [32];

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic            alt;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_val, rs2_val, alu_b, alu_out, jalr_sum;
    logic [4:0]      shamt;
    logic            take;
    logic            wb_en;
    logic [XLEN-1:0] wb_data;
    logic [BE_W-1:0] rd_en, wr_en;

    // Only the low 32 bits carry an instruction; wider XLEN ignores the rest.
    assign instr  = rom_data[31:0];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign alt    = instr[30];

    assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
    assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
    assign imm_j = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    // regs[0] is cleared at reset and never written, so it always reads zero.
    assign rs1_val  = regs[rs1];
    assign rs2_val  = regs[rs2];
    assign pc_plus4 = pc + XLEN'(4);
    assign jalr_sum = rs1_val + imm_i;

    assign rom_addr = pc;
    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign mem_din  = rs2_val;
    assign mem_r    = rstl ? rd_en : '0;
    assign mem_w    = rstl ? wr_en : '0;

    assign alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
    assign shamt = alu_b[4:0];

    always_comb begin
        alu_out = '0;
        case (funct3)
            3'd0: alu_out = (opcode == OP_REG && alt) ? rs1_val - alu_b : rs1_val + alu_b;
            3'd1: alu_out = rs1_val << shamt;
            3'd2: alu_out = XLEN'($signed(rs1_val) < $signed(alu_b));
            3'd3: alu_out = XLEN'(rs1_val < alu_b);
            3'd4: alu_out = rs1_val ^ alu_b;
            3'd5: alu_out = alt ? $unsigned($signed(rs1_val) >>> shamt) : rs1_val >> shamt;
            3'd6: alu_out = rs1_val | alu_b;
            default: alu_out = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'd0: take = (rs1_val == rs2_val);
            3'd1: take = (rs1_val != rs2_val);
            3'd4: take = ($signed(rs1_val) <  $signed(rs2_val));
            3'd5: take = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6: take = (rs1_val <  rs2_val);
            3'd7: take = (rs1_val >= rs2_val);
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = pc_plus4;
        wb_en   = 1'b0;
        wb_data = alu_out;
        rd_en   = '0;
        wr_en   = '0;
        case (opcode)
            OP_IMM, OP_REG: wb_en = 1'b1;
            OP_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OP_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc + imm_u;
            end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                pc_next = pc + imm_j;
            end
            OP_JALR: if (funct3 == 3'd0) begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                pc_next = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OP_BRANCH: if (take) pc_next = pc + imm_b;
            OP_LOAD: begin
                wb_en = 1'b1;
                case (funct3)
                    3'd0: begin rd_en = BE_BYTE; wb_data = {{(XLEN-8){mem_dout[7]}},   mem_dout[7:0]};  end
                    3'd1: begin rd_en = BE_HALF; wb_data = {{(XLEN-16){mem_dout[15]}}, mem_dout[15:0]}; end
                    3'd2: begin rd_en = BE_WORD; wb_data = mem_dout;                                    end
                    3'd4: begin rd_en = BE_BYTE; wb_data = {{(XLEN-8){1'b0}},  mem_dout[7:0]};          end
                    3'd5: begin rd_en = BE_HALF; wb_data = {{(XLEN-16){1'b0}}, mem_dout[15:0]};         end
                    default: wb_en = 1'b0;
                endcase
            end
            OP_STORE: begin
                case (funct3)
                    3'd0:    wr_en = BE_BYTE;
                    3'd1:    wr_en = BE_HALF;
                    3'd2:    wr_en = BE_WORD;
                    default: wr_en = '0;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstl) begin
        if (!rstl) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= pc_next;
            if (wb_en && rd != 5'd0) regs[rd] <= wb_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu
//  Brief    : Directed program bench for cpu with ROM and byte-lane RAM models.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu;

    logic        clk = 1'b0;
    logic        rstl = 1'b0;
    logic [31:0] rom_addr, rom_data, mem_addr, mem_din, mem_dout;
    logic [3:0]  mem_r, mem_w;

    logic [31:0] rom [128];
    logic [7:0]  dmem [256];
    logic        fill_req = 1'b0;
    logic [7:0]  fill_val = 8'h00;

    int          vectors = 0;
    int          miscompares = 0;
    int          pc_w = 0;
    int          halt_pc = 0;
    int          st_off = 0;
    logic [31:0] exp_q [$];

    cpu #(.XLEN(32)) dut (
        .clk      (clk),
        .rstl     (rstl),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .mem_addr (mem_addr),
        .mem_r    (mem_r),
        .mem_w    (mem_w),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr[8:2]];
    assign mem_dout = {dmem[mem_addr[7:0] + 8'd3], dmem[mem_addr[7:0] + 8'd2],
                       dmem[mem_addr[7:0] + 8'd1], dmem[mem_addr[7:0]]};

    // Data memory commits stores on the falling edge.
    always @(negedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 256; i++) dmem[i] <= fill_val;
        end else begin
            for (int i = 0; i < 4; i++)
                if (mem_w[i]) dmem[mem_addr[7:0] + 8'(i)] <= mem_din[8*i +: 8];
        end
    end

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm;
        return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] opi(input int f3, input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, f3, rd, 7'h13);
    endfunction
    function automatic logic [31:0] opr(input int f7, input int f3, input int rd, input int rs1, input int rs2);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] ld(input int f3, input int rd, input int rs1, input int imm);
        return enc_i(imm, rs1, f3, rd, 7'h03);
    endfunction
    function automatic logic [31:0] st(input int f3, input int rs2, input int rs1, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] br(input int f3, input int rs1, input int rs2, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
    endfunction
    function automatic logic [31:0] jal(input int rd, input int imm);
        logic [31:0] v;
        v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
    endfunction
    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        logic [31:0] v;
        v = imm20;
        return {v[19:0], 5'(rd), op};
    endfunction

    function automatic logic [31:0] rd_word(input int a);
        return {dmem[a+3], dmem[a+2], dmem[a+1], dmem[a]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic new_prog();
        for (int i = 0; i < 128; i++) rom[i] = 32'h0;
        pc_w = 0;
    endtask
    task automatic emit(input logic [31:0] ins);
        rom[pc_w] = ins;
        pc_w++;
    endtask
    task automatic halt();
        halt_pc = pc_w * 4;
        emit(jal(0, 0));
    endtask
    // Emit an instruction writing x10, then store x10 to the next result slot.
    task automatic os(input logic [31:0] ins, input logic [31:0] expv);
        emit(ins);
        emit(st(2, 10, 0, st_off));
        exp_q.push_back(expv);
        st_off += 4;
    endtask

    task automatic reset_and_fill(input logic [7:0] fill, input string name);
        rstl     = 1'b0;
        fill_val = fill;
        fill_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        fill_req = 1'b0;
        #1;
        check({name, " reset pc"}, rom_addr, 32'h0);
        check({name, " reset enables"}, {24'h0, mem_r, mem_w}, 32'h0);
    endtask

    task automatic run_prog(input logic [7:0] fill, input string name);
        int n;
        reset_and_fill(fill, name);
        rstl = 1'b1;
        n = 0;
        while (rom_addr !== 32'(halt_pc) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, " reached halt"}, 32'(n < 2000), 32'h1);
    endtask

    initial begin
        // Loads and stores of every width with sign/zero extension.
        new_prog();
        emit(opi(0, 1, 0, -1000));
        emit(st(2, 1, 0, 0));
        emit(ld(0, 2, 0, 0)); emit(st(0, 2, 0, 4));
        emit(ld(4, 3, 0, 0)); emit(st(0, 3, 0, 8));
        emit(ld(1, 4, 0, 0)); emit(st(1, 4, 0, 12));
        emit(ld(5, 5, 0, 0)); emit(st(1, 5, 0, 16));
        emit(ld(2, 6, 0, 0)); emit(st(2, 6, 0, 20));
        emit(st(2, 4, 0, 24));
        emit(st(2, 5, 0, 28));
        emit(ld(0, 7, 0, 1)); emit(st(2, 7, 0, 32));
        halt();
        run_prog(8'h55, "ldst");
        check("ldst sw",      rd_word(0),  32'hFFFFFC18);
        check("ldst lb/sb",   rd_word(4),  32'h55555518);
        check("ldst lbu/sb",  rd_word(8),  32'h55555518);
        check("ldst lh/sh",   rd_word(12), 32'h5555FC18);
        check("ldst lhu/sh",  rd_word(16), 32'h5555FC18);
        check("ldst lw/sw",   rd_word(20), 32'hFFFFFC18);
        check("ldst lh sext", rd_word(24), 32'hFFFFFC18);
        check("ldst lhu zext", rd_word(28), 32'h0000FC18);
        check("ldst lb odd",  rd_word(32), 32'hFFFFFFFC);

        // ALU operations, register and immediate forms.
        new_prog();
        st_off = 0;
        exp_q.delete();
        emit(opi(0, 1, 0, 100));
        emit(opi(0, 2, 0, 101));
        emit(opi(0, 3, 0, 1));
        emit(opi(0, 7, 0, -1000));
        emit(opr(0, 1, 6, 1, 3));
        os(opi(0, 10, 1, 0),        32'd100);
        os(opi(2, 10, 1, 120),      32'd1);
        os(opi(3, 10, 1, 120),      32'd1);
        os(opi(4, 10, 1, 1),        32'd101);
        os(opi(6, 10, 1, 27),       32'd127);
        os(opi(7, 10, 1, 28),       32'd4);
        os(opi(1, 10, 1, 2),        32'd400);
        os(opi(5, 10, 1, 2),        32'd25);
        os(opi(5, 10, 1, 'h402),    32'd25);
        os(opr(0, 0, 10, 1, 2),     32'd201);
        os(opr(32, 0, 10, 1, 2),    32'hFFFFFFFF);
        os(opr(0, 1, 10, 1, 3),     32'd200);
        os(opr(0, 2, 10, 1, 2),     32'd1);
        os(opr(0, 3, 10, 1, 2),     32'd1);
        os(opr(0, 4, 10, 1, 2),     32'd1);
        os(opr(0, 5, 10, 1, 3),     32'd50);
        os(opr(32, 5, 10, 1, 3),    32'd50);
        os(opr(0, 6, 10, 1, 6),     32'd236);
        os(opr(0, 7, 10, 1, 6),     32'd64);
        os(opi(5, 10, 7, 'h402),    32'hFFFFFF06);
        os(opi(5, 10, 7, 2),        32'h3FFFFF06);
        os(opr(32, 5, 10, 7, 3),    32'hFFFFFE0C);
        os(opr(0, 2, 10, 7, 1),     32'd1);
        os(opr(0, 3, 10, 7, 1),     32'd0);
        os(opi(2, 10, 7, -999),     32'd1);
        os(opi(3, 10, 1, -1),       32'd1);
        halt();
        run_prog(8'h5A, "alu");
        for (int k = 0; k < exp_q.size(); k++)
            check($sformatf("alu slot %0d", k), rd_word(4*k), exp_q[k]);

        // Jump chain: jal forward, jalr back (odd target has bit 0 cleared).
        new_prog();
        emit(opi(0, 5, 0, 1));
        emit(jal(31, 16));
        emit(st(0, 5, 0, 1));
        emit(st(2, 29, 0, 8));
        emit(jal(0, 16));
        emit(st(0, 5, 0, 0));
        emit(st(2, 31, 0, 4));
        emit(enc_i(1, 31, 0, 29, 7'h67));
        halt();
        run_prog(8'h00, "jump");
        check("jump bytes 0,1", rd_word(0), 32'h00000101);
        check("jump jal link",  rd_word(4), 32'd8);
        check("jump jalr link", rd_word(8), 32'd32);

        // Branch loops, unsigned and signed.
        new_prog();
        emit(opi(0, 1, 0, 123));
        emit(opi(0, 2, 0, 132));
        emit(opi(0, 5, 0, 1));
        emit(opi(0, 1, 1, 1));
        emit(br(1, 1, 2, -4));
        emit(br(0, 1, 2, 8));
        emit(st(0, 5, 0, 10));
        emit(opi(0, 1, 0, 123));
        emit(opi(0, 1, 1, 1));
        emit(br(6, 1, 2, -4));
        emit(br(7, 1, 2, 8));
        emit(st(0, 5, 0, 10));
        emit(st(0, 5, 0, 2));
        emit(opi(0, 4, 0, -1));
        emit(opi(0, 3, 0, -10));
        emit(opi(0, 3, 3, 1));
        emit(br(4, 3, 4, -4));
        emit(br(5, 3, 4, 8));
        emit(st(0, 5, 0, 10));
        emit(st(0, 5, 0, 3));
        emit(br(6, 4, 1, 8));
        emit(st(0, 5, 0, 11));
        emit(br(4, 4, 1, 8));
        emit(st(0, 5, 0, 10));
        emit(st(2, 3, 0, 12));
        emit(st(2, 1, 0, 16));
        halt();
        run_prog(8'h00, "branch");
        check("branch flags",     rd_word(0),  32'h01010000);
        check("branch skipped",   rd_word(8),  32'h01000000);
        check("branch x3 final",  rd_word(12), 32'hFFFFFFFF);
        check("branch x1 final",  rd_word(16), 32'd132);

        // x0 stays zero, system/unknown opcodes are no-ops, lui/auipc.
        new_prog();
        emit(opi(0, 0, 0, 5));
        emit(st(2, 0, 0, 0));
        emit(32'h00000073);
        emit(32'h0000000F);
        emit(32'hFFFFFFFF);
        emit(enc_u('h12345, 7, 7'h37));
        emit(st(2, 7, 0, 8));
        emit(enc_u(1, 8, 7'h17));
        emit(st(2, 8, 0, 12));
        emit(opi(0, 6, 0, 7));
        emit(st(2, 6, 0, 4));
        emit(st(2, 31, 0, 16));
        halt();
        run_prog(8'hAA, "misc");
        check("misc x0",      rd_word(0),  32'h0);
        check("misc after nop", rd_word(4), 32'd7);
        check("misc lui",     rd_word(8),  32'h12345000);
        check("misc auipc",   rd_word(12), 32'h0000101C);
        check("misc unknown", rd_word(16), 32'h0);

        // Reset mid-program during a store cycle.
        new_prog();
        emit(opi(0, 1, 1, 1));
        emit(st(2, 1, 0, 0));
        emit(jal(0, -8));
        reset_and_fill(8'h00, "rst");
        rstl = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        check("rst pc before", rom_addr, 32'd4);
        check("rst word before", rd_word(0), 32'd2);
        rstl = 1'b0;
        #1;
        check("rst pc async", rom_addr, 32'h0);
        check("rst mem_w async", {28'h0, mem_w}, 32'h0);
        @(negedge clk);
        #1;
        check("rst no store", rd_word(0), 32'd2);
        @(negedge clk);
        #1;
        rstl = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst rerun", rd_word(0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
